// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM stream reader: default geometry, FSM encoding
// and the sizing rule for the read-latency buffer.
package bram_stream_reader_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_RD_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One slot per word that can be in the BRAM pipeline plus the one being presented.
    function automatic int buf_depth(input int rd_latency);
        return rd_latency + 1;
    endfunction

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Small registered-output FIFO absorbing BRAM read latency. Entries shift toward
// slot 0, so head, valid and count all come straight from flops.
module bram_stream_reader_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         valid,
    output logic [WIDTH-1:0]             head
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r      [DEPTH];
    logic [WIDTH-1:0] shifted_s  [DEPTH];
    logic [WIDTH-1:0] mem_nxt_s  [DEPTH];
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [CW-1:0]    wr_idx_s;
    logic             valid_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_pop_s  = pop && (count_r != CW'(0));
    assign do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);

    // Slots at or above count are kept zero, so an empty FIFO presents a zero head.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shifted_s[i] = do_pop_s ? mem_r[i + 1] : mem_r[i];
        end
        shifted_s[DEPTH - 1] = do_pop_s ? {WIDTH{1'b0}} : mem_r[DEPTH - 1];
        wr_idx_s = do_pop_s ? (count_r - CW'(1)) : count_r;
        for (int i = 0; i < DEPTH; i++) begin
            mem_nxt_s[i] = (do_push_s && (wr_idx_s == CW'(i))) ? push_data : shifted_s[i];
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, occupancy and registered valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r <= CW'(0);
            valid_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != CW'(0));
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_nxt_s[i];
            end
        end
    end

    assign count = count_r;
    assign valid = valid_r;
    assign head  = mem_r[0];

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a run of consecutive BRAM words and emits them as a valid/ready stream,
// issuing reads only when the latency buffer is guaranteed room for the result.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int DEPTH = buf_depth(RD_LATENCY);
    localparam int LW    = ADDR_WIDTH + 1;
    localparam int CW    = $clog2(DEPTH + 1);

    state_t                state_r;
    state_t                state_nxt_s;
    logic [LW-1:0]         length_r;
    logic [LW-1:0]         issued_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [RD_LATENCY-1:0] inflight_r;
    logic [RD_LATENCY-1:0] tag_last_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  issue_s;
    logic                  issue_last_s;
    logic                  pop_s;
    logic [DATA_WIDTH:0]   head_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  fifo_valid_s;
    int unsigned           credit_used_s;

    assign pop_s        = fifo_valid_s && out_ready;
    assign issue_last_s = ((issued_r + LW'(1)) == length_r);

    // A read may issue only if every word already owed to the buffer still fits.
    always_comb begin
        credit_used_s = 32'(fifo_count_s);
        for (int i = 0; i < RD_LATENCY; i++) begin
            credit_used_s = credit_used_s + 32'(inflight_r[i]);
        end
        issue_s = (state_r == ST_RUN) && (issued_r < length_r) &&
                  ((credit_used_s < 32'(DEPTH)) || pop_s);
    end

    // Next-state logic; the buffered tag bit marks the word that ends the transfer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (length == LW'(0)) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && head_s[DATA_WIDTH]) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, status flags, address/length counters and the in-flight tag pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            length_r   <= LW'(0);
            issued_r   <= LW'(0);
            mem_addr_r <= ADDR_WIDTH'(0);
            inflight_r <= RD_LATENCY'(0);
            tag_last_r <= RD_LATENCY'(0);
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_r == ST_DONE);
            if ((state_r == ST_IDLE) && start) begin
                length_r   <= length;
                issued_r   <= LW'(0);
                mem_addr_r <= (length != LW'(0)) ? base_addr : mem_addr_r;
            end else if (issue_s) begin
                issued_r   <= issued_r + LW'(1);
                mem_addr_r <= mem_addr_r + ADDR_WIDTH'(1);
            end else begin
                issued_r   <= issued_r;
                mem_addr_r <= mem_addr_r;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                inflight_r[i] <= inflight_r[i - 1];
                tag_last_r[i] <= tag_last_r[i - 1];
            end
            inflight_r[0] <= issue_s;
            tag_last_r[0] <= issue_s && issue_last_s;
        end
    end

    bram_stream_reader_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r[RD_LATENCY-1]),
        .push_data ({tag_last_r[RD_LATENCY-1], mem_data}),
        .pop       (pop_s),
        .count     (fifo_count_s),
        .valid     (fifo_valid_s),
        .head      (head_s)
    );

    assign busy      = busy_r;
    assign done      = done_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wr    = 1'b0;
    assign out_valid = fifo_valid_s;
    assign out_data  = head_s[DATA_WIDTH-1:0];
    assign out_last  = head_s[DATA_WIDTH];

endmodule
